// File: rtl/logic_unit_iter.sv
// rtl/logic_unit_iter.sv - multi-cycle bitwise logic unit evaluating CHUNK bits per clock
module logic_unit_iter #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done,
   output logic             zero
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   // A CHUNK that does not tile WIDTH would leave bits unwritten; refuse to build.
   generate
      if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_chunk_check
         $error("logic_unit_iter: CHUNK must divide WIDTH exactly");
      end
   endgenerate

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [2:0]       r_op;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_result;
   logic             r_busy;
   logic             r_done;
   logic             r_zero;
   logic [WIDTH-1:0] w_func;
   logic [WIDTH-1:0] w_result_next;
   logic             w_last;

   assign w_last = (r_cnt == LAST);

   // Full-width function of the latched operands; only the current slice is used per cycle.
   always_comb begin
      w_func = r_a;
      case (r_op)
         3'b000: w_func = r_a & r_b;
         3'b001: w_func = r_a | r_b;
         3'b010: w_func = r_a ^ r_b;
         3'b011: w_func = ~(r_a | r_b);
         3'b100: w_func = ~(r_a & r_b);
         3'b101: w_func = ~(r_a ^ r_b);
         3'b110: w_func = ~r_a;
         3'b111: w_func = r_a;
      endcase
   end

   // Merge the slice selected by the chunk counter into the running result.
   always_comb begin
      w_result_next = r_result;
      for (int k = 0; k < N; k++) begin
         if (r_cnt == CW'(k)) begin
            w_result_next[k*CHUNK +: CHUNK] = w_func[k*CHUNK +: CHUNK];
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state: start is only honoured when idle, RUN ends on the last slice.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (start)  w_next_state = S_RUN;
         S_RUN:   if (w_last) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Datapath: operand latching, slice accumulation, done pulse and zero flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_zero   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_a      <= a;
                  r_b      <= b;
                  r_op     <= op;
                  r_cnt    <= '0;
                  r_result <= '0;
                  r_zero   <= 1'b0;
                  r_busy   <= 1'b1;
               end
            end
            S_RUN: begin
               r_result <= w_result_next;
               if (w_last) begin
                  r_busy <= 1'b0;
                  r_done <= 1'b1;
                  r_zero <= (w_result_next == '0);
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_done <= 1'b0;
            end
         endcase
      end
   end

   assign result = r_result;
   assign busy   = r_busy;
   assign done   = r_done;
   assign zero   = r_zero;

endmodule

// File: tb/tb_logic_unit_iter.sv
// tb/tb_logic_unit_iter.sv - randomized self-checking bench for logic_unit_iter
module tb_logic_unit_iter;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, start1;
   logic [2:0]  op, op1;
   logic [31:0] a, b, result;
   logic [15:0] a1, b1, result1;
   logic        busy, done, zero;
   logic        busy1, done1, zero1;

   int n_checks = 0;
   int n_fail   = 0;

   logic_unit_iter #(.WIDTH(32), .CHUNK(8)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .result(result), .busy(busy), .done(done), .zero(zero)
   );

   logic_unit_iter #(.WIDTH(16), .CHUNK(16)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .op(op1), .a(a1), .b(b1),
      .result(result1), .busy(busy1), .done(done1), .zero(zero1)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference: whole-word logic function, truncated to the instance width.
   function automatic logic [31:0] ref_fn(input logic [2:0] f, input logic [31:0] x,
                                          input logic [31:0] y, input int w);
      logic [31:0] r;
      logic [31:0] m;
      m = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      case (f)
         3'd0: r = x & y;
         3'd1: r = x | y;
         3'd2: r = x ^ y;
         3'd3: r = ~(x | y);
         3'd4: r = ~(x & y);
         3'd5: r = ~(x ^ y);
         3'd6: r = ~x;
         default: r = x;
      endcase
      return r & m;
   endfunction

   // disturb: 0 quiet, 1 random start/op/a/b noise during RUN, 2 start with op=AND and a=0
   task automatic run32(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input int disturb);
      logic [31:0] exp;
      int cnt;
      exp = ref_fn(f, x, y, 32);
      start = 1'b1; op = f; a = x; b = y;
      tick;
      start = 1'b0;
      check("acc_busy", busy, 1);
      check("acc_done", done, 0);
      check("acc_result", result, 0);
      cnt = 0;
      while (!done && cnt < 20) begin
         if (disturb == 1) begin
            start = 1'($urandom_range(0, 1)); op = 3'($urandom); a = $urandom; b = $urandom;
         end else if (disturb == 2) begin
            start = 1'b1; op = 3'b000; a = 32'h0;
         end
         tick;
         cnt++;
      end
      start = 1'b0;
      check("latency", cnt, 4);
      check("done_result", result, exp);
      check("done_zero", zero, (exp == 32'h0));
      check("done_busy", busy, 0);
      tick;
      check("pulse_once", done, 0);
      check("hold_result", result, exp);
      check("hold_zero", zero, (exp == 32'h0));
   endtask

   task automatic run16(input logic [2:0] f, input logic [15:0] x, input logic [15:0] y);
      logic [31:0] exp;
      int cnt;
      exp = ref_fn(f, {16'h0, x}, {16'h0, y}, 16);
      start1 = 1'b1; op1 = f; a1 = x; b1 = y;
      tick;
      start1 = 1'b0;
      check("w16_acc_busy", busy1, 1);
      cnt = 0;
      while (!done1 && cnt < 10) begin
         tick;
         cnt++;
      end
      check("w16_latency", cnt, 1);
      check("w16_result", result1, exp[15:0]);
      check("w16_zero", zero1, (exp == 32'h0));
      check("w16_busy", busy1, 0);
   endtask

   initial begin
      int cnt;
      reset = 1'b1; start = 1'b0; op = 3'b0; a = '0; b = '0;
      start1 = 1'b0; op1 = 3'b0; a1 = '0; b1 = '0;
      tick;
      tick;
      check("rst_result", result, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_zero", zero, 0);
      check("rst_busy16", busy1, 0);
      reset = 1'b0;
      tick;

      // Directed cases
      run32(3'b011, 32'h0, 32'h0, 0);
      run32(3'b010, 32'hF0F0_A5A5, 32'h0F0F_A5A5, 0);
      run32(3'b000, 32'hFFFF_0000, 32'h0000_FFFF, 0);
      run32(3'b001, 32'h1, 32'h2, 2);
      for (int i = 0; i < 5; i++) begin
         tick;
         check("no_second_done", done, 0);
         check("no_second_busy", busy, 0);
      end

      // Reset during the second RUN cycle aborts with no done
      start = 1'b1; op = 3'b001; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
      tick;
      start = 1'b0;
      tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_result", result, 0);
      check("abort_zero", zero, 0);
      for (int i = 0; i < 6; i++) begin
         tick;
         check("abort_no_done", done, 0);
      end
      run32(3'b101, 32'h0F0F_0F0F, 32'h00FF_00FF, 0);

      // Start held high: back-to-back NANDs, done every 5 cycles
      start = 1'b1; op = 3'b100; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
      tick;
      for (int r = 0; r < 3; r++) begin
         cnt = 0;
         while (!done && cnt < 20) begin
            tick;
            cnt++;
         end
         check("b2b_latency", cnt, 4);
         check("b2b_result", result, 0);
         check("b2b_zero", zero, 1);
         if (r == 2) start = 1'b0;
         tick;
         check("b2b_done_drop", done, 0);
         check("b2b_rearm_busy", busy, (r != 2));
         check("b2b_zero_clear", zero, (r == 2));
      end

      // Randomized operations, quiet and with input noise during RUN
      for (int i = 0; i < 40; i++) begin
         run32(3'($urandom), $urandom, $urandom, (i % 2));
      end

      // Single-slice instance
      run16(3'b110, 16'h1234, 16'h0000);
      for (int i = 0; i < 10; i++) begin
         run16(3'($urandom), 16'($urandom), 16'($urandom));
      end
      run16(3'b111, 16'h0000, 16'hFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
